// File: rtl/modmul_sched_pkg.sv
// Shared definitions for the modular-multiplier issue scheduler: default
// sizing and the in-flight tracking entry carried down the latency pipe.
package modmul_sched_pkg;

  localparam int DEF_NREQ   = 4;
  localparam int DEF_WORDSZ = 16;
  localparam int DEF_LAT    = 34;
  localparam int RNW        = 4;
  // Wide enough for the largest supported requester count (8).
  localparam int ID_W       = 3;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic [RNW-1:0]  rd;
  } flight_t;

endpackage

// File: rtl/modmul_sched_arbiter.sv
// NREQ-way round-robin arbiter: searches from the slot after the last winner
// and moves the pointer only when the caller accepts the grant.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] elig_i,
  input  logic            advance_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  ptr_o
);

  logic [IDW-1:0] last_q;
  logic [IDW-1:0] last_d;
  logic [IDW-1:0] gntIdx;
  logic [IDW-1:0] cand;
  logic           found;

  always_comb begin
    grant_o = '0;
    gntIdx  = last_q;
    cand    = '0;
    found   = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last_q) + k) % NREQ);
      if (!found && elig_i[cand]) begin
        grant_o[cand] = 1'b1;
        gntIdx        = cand;
        found         = 1'b1;
      end
    end
  end

  // ptr_o is the pointer after this cycle's advance, i.e. the winner's index.
  always_comb begin
    last_d = advance_i ? gntIdx : last_q;
    ptr_o  = last_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= IDW'(NREQ - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/modmul_sched.sv
// Shares one pipelined modular multiplier among NREQ requesters, blocking
// write-after-write on destination registers and tagging returned results.
module modmul_sched
  import modmul_sched_pkg::*;
#(
  parameter  int NREQ   = DEF_NREQ,
  parameter  int WORDSZ = DEF_WORDSZ,
  parameter  int LAT    = DEF_LAT,
  localparam int IDW    = $clog2(NREQ),
  localparam int PW     = 2**RNW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*WORDSZ-1:0] req_a,
  input  logic [NREQ*WORDSZ-1:0] req_b,
  input  logic [NREQ*RNW-1:0]    req_rd,
  output logic                   mm_en,
  output logic [WORDSZ-1:0]      mm_a,
  output logic [WORDSZ-1:0]      mm_b,
  output logic [RNW-1:0]         mm_rn,
  input  logic [WORDSZ-1:0]      mm_res,
  input  logic [RNW-1:0]         mm_rn_ret,
  output logic                   rsp_valid,
  output logic [IDW-1:0]         rsp_id,
  output logic [RNW-1:0]         rsp_rd,
  output logic [WORDSZ-1:0]      rsp_data,
  output logic [PW-1:0]          pend_map,
  output logic                   idle,
  output logic                   tag_err
);

  logic [NREQ-1:0]   elig;
  logic [NREQ-1:0]   grant;
  logic [IDW-1:0]    gntPtr;
  logic              granted;
  logic [WORDSZ-1:0] selA;
  logic [WORDSZ-1:0] selB;
  logic [RNW-1:0]    selRd;
  logic [PW-1:0]     setVec;
  logic [PW-1:0]     clrVec;
  logic              anyFlight;
  flight_t           push;
  flight_t           tail;

  logic              mmEn_q, mmEn_d;
  logic [WORDSZ-1:0] mmA_q, mmA_d;
  logic [WORDSZ-1:0] mmB_q, mmB_d;
  logic [RNW-1:0]    mmRn_q, mmRn_d;
  logic              rspValid_q, rspValid_d;
  logic [IDW-1:0]    rspId_q, rspId_d;
  logic [RNW-1:0]    rspRd_q, rspRd_d;
  logic [WORDSZ-1:0] rspData_q, rspData_d;
  logic [PW-1:0]     pend_q, pend_d;
  logic              tagErr_q, tagErr_d;
  flight_t           sr_q [0:LAT];

  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = req_valid[i] & ~pend_q[req_rd[i*RNW +: RNW]];
    end
  end

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .elig_i    (elig),
    .advance_i (granted),
    .grant_o   (grant),
    .ptr_o     (gntPtr)
  );

  assign granted   = |grant;
  assign req_ready = grant;

  always_comb begin
    selA  = '0;
    selB  = '0;
    selRd = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        selA  = req_a[i*WORDSZ +: WORDSZ];
        selB  = req_b[i*WORDSZ +: WORDSZ];
        selRd = req_rd[i*RNW +: RNW];
      end
    end
  end

  assign tail = sr_q[LAT];

  // A bit is only set while clear and only cleared while set, so the two
  // vectors never touch the same register in one cycle.
  always_comb begin
    mmEn_d     = granted;
    mmA_d      = selA;
    mmB_d      = selB;
    mmRn_d     = selRd;
    push       = '0;
    push.valid = granted;
    push.id    = granted ? ID_W'(gntPtr) : '0;
    push.rd    = selRd;
    setVec     = granted ? (PW'(1) << selRd) : '0;
    clrVec     = tail.valid ? (PW'(1) << tail.rd) : '0;
    pend_d     = (pend_q & ~clrVec) | setVec;
    rspValid_d = tail.valid;
    rspId_d    = tail.valid ? IDW'(tail.id) : '0;
    rspRd_d    = tail.valid ? tail.rd : '0;
    rspData_d  = tail.valid ? mm_res : '0;
    tagErr_d   = tagErr_q | (tail.valid & (mm_rn_ret != tail.rd));
  end

  always_comb begin
    anyFlight = 1'b0;
    for (int k = 0; k <= LAT; k++) begin
      anyFlight = anyFlight | sr_q[k].valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mmEn_q     <= 1'b0;
      mmA_q      <= '0;
      mmB_q      <= '0;
      mmRn_q     <= '0;
      rspValid_q <= 1'b0;
      rspId_q    <= '0;
      rspRd_q    <= '0;
      rspData_q  <= '0;
      pend_q     <= '0;
      tagErr_q   <= 1'b0;
      for (int k = 0; k <= LAT; k++) begin
        sr_q[k] <= '0;
      end
    end else begin
      mmEn_q     <= mmEn_d;
      mmA_q      <= mmA_d;
      mmB_q      <= mmB_d;
      mmRn_q     <= mmRn_d;
      rspValid_q <= rspValid_d;
      rspId_q    <= rspId_d;
      rspRd_q    <= rspRd_d;
      rspData_q  <= rspData_d;
      pend_q     <= pend_d;
      tagErr_q   <= tagErr_d;
      sr_q[0]    <= push;
      for (int k = 1; k <= LAT; k++) begin
        sr_q[k] <= sr_q[k-1];
      end
    end
  end

  assign mm_en     = mmEn_q;
  assign mm_a      = mmA_q;
  assign mm_b      = mmB_q;
  assign mm_rn     = mmRn_q;
  assign rsp_valid = rspValid_q;
  assign rsp_id    = rspId_q;
  assign rsp_rd    = rspRd_q;
  assign rsp_data  = rspData_q;
  assign pend_map  = pend_q;
  assign idle      = ~anyFlight & ~mmEn_q;
  assign tag_err   = tagErr_q;

endmodule
